// File: rtl/multy_seq.sv
// Iterative WIDTH x WIDTH signed/unsigned multiplier with start/busy/done handshake.
// Define MULTY_ACC_EN to add the captured acc_in term to the product (MADD/MADDU).
module multy_seq #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 flush,
  input  logic                 isSigned,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   acc_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, stateNext;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   partial;
  logic [CNT_W-1:0]     count;
  logic                 resNeg;
  logic [WIDTH-1:0]     aMag, bMag;
  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   product;
  logic [2*WIDTH-1:0]   result;
  logic                 accept;
  logic                 lastCount;

  // Magnitudes stay WIDTH-bit unsigned so the most negative operand is exact.
  assign aMag      = (isSigned && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign bMag      = (isSigned && b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign accept    = start && !flush;
  assign lastCount = (count == CNT_W'(N - 1));
  assign product   = resNeg ? (~partial + 1'b1) : partial;

`ifdef MULTY_ACC_EN
  logic [2*WIDTH-1:0] accReg;
  assign result = product + accReg;
`else
  logic unusedAcc;
  assign unusedAcc = ^acc_in;
  assign result    = product;
`endif

  // mcand is pre-shifted each step, so bit k of the digit adds mcand << k.
  always_comb begin
    addend = '0;
    for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
      if (mplier[k]) addend = addend + (mcand << k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (accept) stateNext = CALC;
      CALC:    if (flush) stateNext = IDLE;
               else if (lastCount) stateNext = FIX;
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      partial <= '0;
      count   <= '0;
      resNeg  <= 1'b0;
      done    <= 1'b0;
      z       <= '0;
`ifdef MULTY_ACC_EN
      accReg  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            mcand   <= {{WIDTH{1'b0}}, aMag};
            mplier  <= bMag;
            partial <= '0;
            count   <= '0;
            resNeg  <= isSigned & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULTY_ACC_EN
            accReg  <= acc_in;
`endif
          end
        end
        CALC: begin
          if (!flush) begin
            partial <= partial + addend;
            mcand   <= mcand << BITS_PER_CYCLE;
            mplier  <= mplier >> BITS_PER_CYCLE;
            count   <= count + 1'b1;
          end
        end
        FIX: begin
          if (!flush) begin
            z    <= result;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multy_seq.sv
// Directed bench for multy_seq: 32-bit vector table, handshake/abort sequences,
// and WIDTH=8 instances at 1/2/4 bits per cycle against a reference product.
module tb_multy_seq;

`ifdef MULTY_ACC_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, flush = 1'b0, isSigned = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [63:0] accIn = '0;
  logic        busy, done;
  logic [63:0] z;

  logic        start8 = 1'b0, flush8 = 1'b0, signed8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] acc8 = '0;
  logic        busy8 [3];
  logic        done8 [3];
  logic [15:0] z8 [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multy_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .isSigned(isSigned),
    .a(a), .b(b), .acc_in(accIn), .busy(busy), .done(done), .z(z));

  multy_seq #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8x1 (
    .clk(clk), .rst(rst), .start(start8), .flush(flush8), .isSigned(signed8),
    .a(a8), .b(b8), .acc_in(acc8), .busy(busy8[0]), .done(done8[0]), .z(z8[0]));
  multy_seq #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut8x2 (
    .clk(clk), .rst(rst), .start(start8), .flush(flush8), .isSigned(signed8),
    .a(a8), .b(b8), .acc_in(acc8), .busy(busy8[1]), .done(done8[1]), .z(z8[1]));
  multy_seq #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut8x4 (
    .clk(clk), .rst(rst), .start(start8), .flush(flush8), .isSigned(signed8),
    .a(a8), .b(b8), .acc_in(acc8), .busy(busy8[2]), .done(done8[2]), .z(z8[2]));

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] acc;
    logic [63:0] zPlain;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] x, input logic [7:0] y);
    logic signed [15:0] sx, sy;
    if (s) begin
      sx = {{8{x[7]}}, x};
      sy = {{8{y[7]}}, y};
      return 16'(sx * sy);
    end
    return {8'h00, x} * {8'h00, y};
  endfunction

  // Launches one 32-bit op, scrambles inputs after the start edge, waits for done.
  task automatic runOp(input logic s, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] accv, output int lat, output logic busyBad);
    @(negedge clk);
    isSigned = s; a = av; b = bv; accIn = accv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; isSigned = ~s; accIn = {$urandom, $urandom};
    lat = 0;
    busyBad = 1'b0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (done) lat = c;
      else if (!busy) busyBad = 1'b1;
    end
  endtask

  initial begin
    int          lat, cnt;
    logic        busyBad;
    logic [63:0] zSeen, zPrev;
    logic [7:0]  pat [10];
    int          lat8 [3];
    logic [15:0] zc8 [3];
    int          expLat8 [3];

    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0, 64'h0000_0001_FFFF_FFFE};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h0, 64'h4000_0000_0000_0000};
    vecs[4] = '{1'b1, 32'h0000_0003, 32'hFFFF_FFFC, 64'h10, 64'hFFFF_FFFF_FFFF_FFF4};
    vecs[5] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 64'h1, 64'h0};
    vecs[6] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 64'h0, 64'hFFFF_FFFF_8000_0000};
    vecs[7] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'h0, 64'hC000_0000_8000_0000};
    vecs[8] = '{1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0, 64'h0000_0001_2345_6780};
    vecs[9] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'h0000_0000_0000_0001};

    pat = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h55, 8'h0D};
    expLat8 = '{9, 5, 3};

    #3;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset z", z, 64'd0);
    chk("reset z8", {48'd0, z8[0]}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      runOp(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].acc, lat, busyBad);
      chk($sformatf("vec%0d latency", i), lat, 33);
      chk($sformatf("vec%0d z", i), z, vecs[i].zPlain + (ACC_ON ? vecs[i].acc : 64'd0));
      chk($sformatf("vec%0d busy held", i), {63'd0, busyBad}, 64'd0);
      chk($sformatf("vec%0d busy low at done", i), {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      chk($sformatf("vec%0d done one cycle", i), {63'd0, done}, 64'd0);
    end

    // start re-asserted mid-operation must be ignored
    @(negedge clk);
    isSigned = 1'b0; a = 32'hFFFF_FFFF; b = 32'h2; accIn = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0; lat = 0; zSeen = '0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (done) begin
        cnt++;
        if (lat == 0) begin lat = c; zSeen = z; end
      end
      if (c == 9) begin start = 1'b1; a = 32'd5; b = 32'd7; isSigned = 1'b1; end
      if (c == 10) start = 1'b0;
    end
    chk("ignored start done count", cnt, 1);
    chk("ignored start latency", lat, 33);
    chk("ignored start z", zSeen, 64'h0000_0001_FFFF_FFFE);

    // start in the done cycle launches the next op back to back
    runOp(1'b1, 32'hFFFF_FFFF, 32'h2, 64'h0, lat, busyBad);
    chk("b2b first z", z, 64'hFFFF_FFFF_FFFF_FFFE);
    start = 1'b1; isSigned = 1'b1; a = 32'hFFFF_FFF9; b = 32'd6; accIn = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b busy after restart", {63'd0, busy}, 64'd1);
    lat = 0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (done) lat = c;
    end
    chk("b2b second latency", lat, 33);
    chk("b2b second z", z, 64'hFFFF_FFFF_FFFF_FFD6);
    zPrev = 64'hFFFF_FFFF_FFFF_FFD6;

    // flush at cycle 12 aborts with no done and z untouched
    @(negedge clk);
    isSigned = 1'b0; a = 32'd100; b = 32'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy drop", {63'd0, busy}, 64'd0);
    cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk("flush no done", cnt, 0);
    chk("flush z held", z, zPrev);

    // flush wins over start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush+start busy", {63'd0, busy}, 64'd0);
    cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk("flush+start no done", cnt, 0);

    // asynchronous reset mid-CALC
    @(negedge clk);
    isSigned = 1'b0; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
    end
    #1 rst = 1'b1;
    #1;
    chk("async rst busy", {63'd0, busy}, 64'd0);
    chk("async rst done", {63'd0, done}, 64'd0);
    chk("async rst z", z, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk("after rst no done", cnt, 0);
    runOp(1'b0, 32'd9, 32'd9, 64'h0, lat, busyBad);
    chk("after rst op z", z, 64'd81);
    chk("after rst op latency", lat, 33);

    // WIDTH=8 instances at 1, 2, 4 bits per cycle
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 10; i++) begin
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          signed8 = 1'(s); a8 = pat[i]; b8 = pat[j]; start8 = 1'b1;
          @(posedge clk); #1;
          start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); signed8 = ~signed8;
          lat8 = '{0, 0, 0};
          for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
              if (done8[k] && lat8[k] == 0) begin
                lat8[k] = c;
                zc8[k] = z8[k];
              end
            end
          end
          for (int k = 0; k < 3; k++) begin
            chk($sformatf("w8 bpc%0d latency s=%0d a=%h b=%h", 1 << k, s, pat[i], pat[j]),
                lat8[k], expLat8[k]);
            chk($sformatf("w8 bpc%0d z s=%0d a=%h b=%h", 1 << k, s, pat[i], pat[j]),
                {48'd0, zc8[k]}, {48'd0, ref8(1'(s), pat[i], pat[j])});
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
